mdu_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide operations, so they no longer sit in the single-cycle ALU path.
- Accepts one request from the execute stage, multiplies in 2 cycles or divides with a 32-iteration restoring divider, then returns a single-cycle result pulse.
- Drives busy so the pipeline stalls while an operation is outstanding.

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu_div_step.sv | 26 ++
 rtl/mdu_seq.sv | 189 ++++++++++++++++++
 tb/tb_mdu_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// The ALU_* opcodes mirror the execute stage's define.vh encodings.
// Optional build macro: MDU_FAST_SPECIAL_EN (resolves trivial divides at accept).
package mdu_pkg;

  localparam logic [5:0] ALU_ADD    = 6'd0;
  localparam logic [5:0] ALU_SUB    = 6'd1;
  localparam logic [5:0] ALU_XOR    = 6'd4;
  localparam logic [5:0] ALU_MUL    = 6'd20;
  localparam logic [5:0] ALU_MULH   = 6'd21;
  localparam logic [5:0] ALU_MULHSU = 6'd22;
  localparam logic [5:0] ALU_MULHU  = 6'd23;
  localparam logic [5:0] ALU_DIV    = 6'd24;
  localparam logic [5:0] ALU_DIVU   = 6'd25;
  localparam logic [5:0] ALU_REM    = 6'd26;
  localparam logic [5:0] ALU_REMU   = 6'd27;

  localparam logic [31:0] MINUS1  = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  function automatic logic is_mul_op(input logic [5:0] code);
    return (code == ALU_MUL) || (code == ALU_MULH) ||
           (code == ALU_MULHSU) || (code == ALU_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [5:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU) ||
           (code == ALU_REM) || (code == ALU_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [5:0] code);
    return (code == ALU_DIV) || (code == ALU_REM);
  endfunction

  function automatic logic is_rem(input logic [5:0] code);
    return (code == ALU_REM) || (code == ALU_REMU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference only if it did not go negative.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Trial subtraction one bit wider than the operands; its MSB is the borrow.
  always_comb begin
    shifted  = {rem, dvd_bit};
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[XLEN];
    rem_next = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M sequencer: 2-cycle multiply, 32-iteration restoring
// divide, single-cycle result pulse, busy while an operation is outstanding.
// Optional build macro: MDU_FAST_SPECIAL_EN -- divide-by-zero, signed
// overflow and |dividend| < |divisor| finish one cycle after accept.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [5:0]      alucode,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            resp_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_t state, state_next;

  logic [5:0]      op_reg;
  logic [XLEN-1:0] op1_reg;     // raw dividend, returned by REM/REMU on /0
  logic [XLEN-1:0] dvd_reg;     // dividend magnitude, shifts left into quotient
  logic [XLEN-1:0] dvs_reg;     // divisor magnitude
  logic [XLEN-1:0] rem_reg;     // partial remainder
  logic [CNT_W-1:0] cnt_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic            dvs_zero_reg;
  logic            ovf_reg;
  logic [2*XLEN+1:0] prod_reg;
  logic [XLEN-1:0] result_reg;

  logic accept;
  logic sgn_div;
  logic [XLEN-1:0] dvd_mag, dvs_mag;
  logic div_zero, div_ovf;
  logic fast_special;
  logic [XLEN-1:0] fast_result;
  logic signed [XLEN:0]     a_ext, b_ext;
  logic signed [2*XLEN+1:0] prod_full;

  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [XLEN-1:0] q_raw, q_fix, r_fix, div_final, mul_result;
  logic            last_iter;
  logic            unused_prod_top;

  assign accept    = req_valid & req_ready & ~flush;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign resp_valid = (state == DONE) & ~flush;
  assign result    = result_reg;
  assign last_iter = (cnt_reg == CNT_W'(XLEN - 1));

  // Accept-time operand conditioning: magnitudes, special cases, product.
  always_comb begin
    sgn_div  = is_signed_div(alucode);
    dvd_mag  = (sgn_div && op1[XLEN-1]) ? -op1 : op1;
    dvs_mag  = (sgn_div && op2[XLEN-1]) ? -op2 : op2;
    div_zero = (op2 == '0);
    div_ovf  = sgn_div && (op1 == MIN_INT) && (op2 == MINUS1);
    a_ext    = {((alucode == ALU_MULH) || (alucode == ALU_MULHSU)) & op1[XLEN-1], op1};
    b_ext    = {(alucode == ALU_MULH) & op2[XLEN-1], op2};
    prod_full = (2*XLEN+2)'(a_ext) * (2*XLEN+2)'(b_ext);
  end

`ifdef MDU_FAST_SPECIAL_EN
  // Trivial divides resolved without iterating.
  always_comb begin
    fast_special = div_zero || div_ovf || (dvd_mag < dvs_mag);
    if (is_rem(alucode))
      fast_result = div_zero ? op1 : (div_ovf ? '0 : op1);
    else
      fast_result = div_zero ? MINUS1 : (div_ovf ? MIN_INT : '0);
  end
`else
  assign fast_special = 1'b0;
  assign fast_result  = '0;
`endif

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (rem_reg),
    .dvd_bit  (dvd_reg[XLEN-1]),
    .divisor  (dvs_reg),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Final sign fix-up, with the RISC-V defined results for /0 and overflow.
  always_comb begin
    q_raw = {dvd_reg[XLEN-2:0], step_q};
    q_fix = neg_q_reg ? -q_raw : q_raw;
    r_fix = neg_r_reg ? -step_rem : step_rem;
    if (dvs_zero_reg)
      div_final = is_rem(op_reg) ? op1_reg : MINUS1;
    else if (ovf_reg)
      div_final = is_rem(op_reg) ? '0 : MIN_INT;
    else
      div_final = is_rem(op_reg) ? r_fix : q_fix;
    mul_result = (op_reg == ALU_MUL) ? prod_reg[XLEN-1:0] : prod_reg[2*XLEN-1:XLEN];
  end

  // The top two product bits only exist to hold the signed-extension carry.
  assign unused_prod_top = ^prod_reg[2*XLEN+1:2*XLEN];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush kills any in-flight operation.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul_op(alucode))      state_next = MUL;
          else if (is_div_op(alucode)) state_next = fast_special ? DONE : DIV;
          else                         state_next = DONE;
        end
      end
      MUL:  state_next = DONE;
      DIV:  if (last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush && (state != IDLE)) state_next = IDLE;
  end

  // Datapath: latch on accept, iterate in DIV, load result on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg       <= '0;
      op1_reg      <= '0;
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dvs_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      prod_reg     <= '0;
      result_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_reg       <= alucode;
            op1_reg      <= op1;
            dvd_reg      <= dvd_mag;
            dvs_reg      <= dvs_mag;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            neg_q_reg    <= sgn_div & (op1[XLEN-1] ^ op2[XLEN-1]);
            neg_r_reg    <= sgn_div & op1[XLEN-1];
            dvs_zero_reg <= div_zero;
            ovf_reg      <= div_ovf;
            prod_reg     <= prod_full;
            if (!is_mul_op(alucode) && !is_div_op(alucode))
              result_reg <= '0;
            else if (is_div_op(alucode) && fast_special)
              result_reg <= fast_result;
          end
        end
        MUL: begin
          if (!flush) result_reg <= mul_result;
        end
        DIV: begin
          if (!flush) begin
            rem_reg <= step_rem;
            dvd_reg <= {dvd_reg[XLEN-2:0], step_q};
            cnt_reg <= cnt_reg + 1'b1;
            if (last_iter) result_reg <= div_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed cases plus random operations,
// scored against a plain-arithmetic RV32M model through a response queue.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  alucode = ALU_ADD;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] result;
  logic        busy;

  mdu_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .alucode(alucode), .op1(op1), .op2(op2), .flush(flush),
    .resp_valid(resp_valid), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference RV32M semantics using 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      ALU_MUL:    begin p = sa * sb; return p[31:0];  end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      ALU_DIVU: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      ALU_REMU: begin if (b == 0) return a;             p = ua % ub; return p[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    bit sgn;
    if (op == ALU_MUL || op == ALU_MULH || op == ALU_MULHSU || op == ALU_MULHU) return 2;
    if (op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU) begin
      sgn = (op == ALU_DIV || op == ALU_REM);
      ma = sgn ? longint'($signed(a)) : longint'({32'b0, a});
      mb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
`ifdef MDU_FAST_SPECIAL_EN
      if (b == 0) return 1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      if (ma < mb) return 1;
`endif
      return 33;
    end
    return 1;
  endfunction

  // Monitor: every response must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {31'b0, resp_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("latency", cyc - e.acc + 1, e.lat);
          $display("resp op=%0d a=0x%08h b=0x%08h result=0x%08h lat=%0d",
                   e.op, e.a, e.b, result, cyc - e.acc + 1);
        end
      end
    end
  end

  // Drive one request; returns just after the accept edge.
  task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; alucode = op; op1 = a; op2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0; alucode = ALU_ADD; op1 = $urandom; op2 = $urandom;
  endtask

  // Full scored operation: expect one response, busy held, ready low.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit bad;
    int n;
    @(negedge clk);
    req_valid = 1'b1; alucode = op; op1 = a; op2 = b;
    @(posedge clk); #1;
    e.op = op; e.a = a; e.b = b;
    e.res = ref_result(op, a, b);
    e.lat = ref_latency(op, a, b);
    e.acc = cyc;
    exp_q.push_back(e);
    req_valid = 1'b0; alucode = ALU_ADD; op1 = $urandom; op2 = $urandom;
    bad = 1'b0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1 || req_ready !== 1'b0) bad = 1'b1;
    end while (resp_valid !== 1'b1 && n < 60);
    check("resp_seen", {31'b0, resp_valid}, 32'h1);
    check("busy_hold", {31'b0, bad}, 32'h0);
    last_res = e.res;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] op_tab [0:10];

  initial begin
    op_tab[0] = ALU_MUL;  op_tab[1] = ALU_MULH; op_tab[2]  = ALU_MULHSU; op_tab[3] = ALU_MULHU;
    op_tab[4] = ALU_DIV;  op_tab[5] = ALU_DIVU; op_tab[6]  = ALU_REM;    op_tab[7] = ALU_REMU;
    op_tab[8] = ALU_ADD;  op_tab[9] = ALU_SUB;  op_tab[10] = ALU_XOR;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp", {31'b0, resp_valid}, 32'h0);
    check("rst_result", result, 32'h0);

    // Multiply corner operands
    run_op(ALU_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(ALU_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Signed divide with negative dividend
    run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2);

    // Overflow and divide-by-zero
    run_op(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(ALU_DIVU, 32'd5, 32'd0);
    run_op(ALU_REMU, 32'd5, 32'd0);
    run_op(ALU_DIV,  32'hFFFF_FFFB, 32'd0);
    run_op(ALU_REM,  32'hFFFF_FFFB, 32'd0);
    run_op(ALU_DIVU, 32'd3, 32'd10);

    // Flush in the middle of a divide
    start_op(ALU_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    check("flush_div_resp", {31'b0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_div_busy", {31'b0, busy}, 32'h0);
    check("flush_div_ready", {31'b0, req_ready}, 32'h1);
    check("flush_div_result", result, last_res);
    run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'd2);

    // Flush during a multiply keeps the previous result
    start_op(ALU_MUL, 32'd3, 32'd5);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_mul_busy", {31'b0, busy}, 32'h0);
    check("flush_mul_result", result, last_res);

    // Flush alongside a request in IDLE blocks the accept
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; alucode = ALU_DIV; op1 = 32'd9; op2 = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", {31'b0, busy}, 32'h0);

    // Random operations
    for (int i = 0; i < 150; i++)
      run_op(op_tab[$urandom_range(0, 10)], pick_operand(), pick_operand());

    // Result holds while idle
    run_op(ALU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (4) @(negedge clk);
    check("result_hold", result, last_res);

    // Reset in the middle of a divide
    start_op(ALU_DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_resp", {31'b0, resp_valid}, 32'h0);
    check("rst_mid_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Non-M opcode after reset
    run_op(ALU_ADD, 32'd7, 32'd9);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
